// File: rtl/fifo_axis_framer.sv
// fifo_axis_framer: drains the 64-bit read side of the sample FIFO into fixed-length
// AXI4-Stream frames (tlast on the final beat). Capture starts and stops only on frame
// boundaries. A 2-entry output buffer covers the 1-cycle FIFO read latency so the stream
// can run at one beat per cycle under backpressure.
module fifo_axis_framer #(
  parameter int DATA_W      = 64,
  parameter int FRAME_BEATS = 256,
  parameter int CNT_W       = 32
) (
  input  logic              clk_0,
  input  logic              resetn_0,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_count
);

  localparam int BW = (FRAME_BEATS > 2) ? $clog2(FRAME_BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_BEATS - 1);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] buf0_q, buf0_d, buf1_q, buf1_d;   // buf0 is the stream head
  logic              vld0_q, vld0_d, vld1_q, vld1_d;
  logic              inflight_q, inflight_d;           // read issued last cycle
  logic [BW-1:0]     req_cnt_q, req_cnt_d;
  logic [BW-1:0]     out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

  logic       hs, last_hs, req_open, frame_clear;
  logic [1:0] load;

  assign m_axis_tdata  = buf0_q;
  assign m_axis_tvalid = vld0_q;
  assign m_axis_tlast  = vld0_q && (out_cnt_q == LAST_BEAT);
  assign busy          = (state_q != IDLE);
  assign frame_count   = frame_cnt_q;

  // Read credit: buffered + in-flight words, less the one leaving this cycle, must leave a
  // free slot. Counting the departing beat is what sustains one beat per cycle.
  always_comb begin
    hs       = vld0_q && m_axis_tready;
    last_hs  = hs && (out_cnt_q == LAST_BEAT);
    load     = 2'(vld0_q) + 2'(vld1_q) + 2'(inflight_q) - 2'(hs);
    req_open = (state_q == RUN) || (req_cnt_q != '0);
    fifo_rd_en = !fifo_empty && (state_q != IDLE) && req_open && (load < 2'd2);
  end

  // Output buffer: capture the read data returned this cycle, pop the head on handshake.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    vld0_d = vld0_q;
    vld1_d = vld1_q;
    if (inflight_q) begin
      if (hs) begin
        if (vld1_q) begin
          buf0_d = buf1_q;
          buf1_d = fifo_rd_data;
        end else begin
          buf0_d = fifo_rd_data;
        end
      end else if (!vld0_q) begin
        buf0_d = fifo_rd_data;
        vld0_d = 1'b1;
      end else begin
        buf1_d = fifo_rd_data;
        vld1_d = 1'b1;
      end
    end else if (hs) begin
      buf0_d = buf1_q;
      vld0_d = vld1_q;
      vld1_d = 1'b0;
    end
  end

  // Beat counters for the request and output sides, and the completed-frame counter.
  always_comb begin
    inflight_d  = fifo_rd_en;
    req_cnt_d   = req_cnt_q;
    out_cnt_d   = out_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (fifo_rd_en) req_cnt_d = (req_cnt_q == LAST_BEAT) ? '0 : req_cnt_q + BW'(1);
    if (hs)         out_cnt_d = (out_cnt_q == LAST_BEAT) ? '0 : out_cnt_q + BW'(1);
    if (last_hs)    frame_cnt_d = frame_cnt_q + CNT_W'(1);
  end

  // Stopping returns to IDLE only once nothing of any frame remains requested, in flight,
  // buffered or partly sent. A read of the next frame issued before the stop was seen
  // makes STOP finish that frame too, so the host never gets a partial record.
  always_comb begin
    frame_clear = !vld0_d && !vld1_d && !fifo_rd_en &&
                  (req_cnt_d == '0) && (out_cnt_d == '0);
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = frame_clear ? IDLE : STOP;
      STOP:    if (frame_clear) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards buffered and in-flight data.
  always_ff @(posedge clk_0 or negedge resetn_0) begin
    if (!resetn_0) begin
      state_q     <= IDLE;
      buf0_q      <= '0;
      buf1_q      <= '0;
      vld0_q      <= 1'b0;
      vld1_q      <= 1'b0;
      inflight_q  <= 1'b0;
      req_cnt_q   <= '0;
      out_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      vld0_q      <= vld0_d;
      vld1_q      <= vld1_d;
      inflight_q  <= inflight_d;
      req_cnt_q   <= req_cnt_d;
      out_cnt_q   <= out_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_axis_framer.sv
// Directed bench for fifo_axis_framer with FRAME_BEATS=4 and a behavioural FIFO read port.
module tb_fifo_axis_framer;
  localparam int DW = 64;
  localparam int FB = 4;
  localparam int CW = 32;

  logic          clk_0 = 1'b0;
  logic          resetn_0, enable, fifo_empty, fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast, busy;
  logic [CW-1:0] frame_count;

  fifo_axis_framer #(.DATA_W(DW), .FRAME_BEATS(FB), .CNT_W(CW)) dut (
    .clk_0(clk_0), .resetn_0(resetn_0), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .busy(busy), .frame_count(frame_count)
  );

  always #5 clk_0 = ~clk_0;

  // FIFO read side: data valid one cycle after rd_en
  logic [DW-1:0] mem [0:255];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  logic flush  = 1'b0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk_0) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // Stream monitor: beat log, hold-while-stalled and outstanding-word bound
  logic [DW-1:0] obs_d [$];
  logic          obs_l [$];
  int            obs_c [$];
  int            rd_c  [$];
  int            cyc = 0, stall_err = 0, ovf_err = 0, bal = 0;
  logic          pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [DW-1:0] pd = '0;

  always @(posedge clk_0) begin
    cyc <= cyc + 1;
    if (resetn_0) begin
      if (m_axis_tvalid && m_axis_tready) begin
        obs_d.push_back(m_axis_tdata);
        obs_l.push_back(m_axis_tlast);
        obs_c.push_back(cyc);
      end
      if (fifo_rd_en) rd_c.push_back(cyc);
      if (pv && !pr && (!m_axis_tvalid || m_axis_tdata != pd || m_axis_tlast != pl))
        stall_err <= stall_err + 1;
      if (bal > 2) ovf_err <= ovf_err + 1;
      bal <= bal + int'(fifo_rd_en) - int'(m_axis_tvalid && m_axis_tready);
    end else begin
      bal <= 0;
    end
    pv <= m_axis_tvalid;
    pr <= m_axis_tready;
    pd <= m_axis_tdata;
    pl <= m_axis_tlast;
  end

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk_0);
    flush = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int k = 0;
    while (obs_d.size() < n && k < budget) begin
      @(negedge clk_0);
      k++;
    end
    chk(tag, obs_d.size(), n);
  endtask

  initial begin
    int b, r, k;
    resetn_0 = 1'b0; enable = 1'b0; m_axis_tready = 1'b0;
    repeat (3) @(negedge clk_0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fcount", frame_count, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    resetn_0 = 1'b1;

    // enable low with data waiting: nothing moves
    push(64'hA1); push(64'hA2); push(64'hA3);
    repeat (6) @(negedge clk_0);
    chk("idle_rd_en", fifo_rd_en, 0);
    chk("idle_tvalid", m_axis_tvalid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_reads", rd_c.size(), 0);
    do_flush();

    // two full-rate frames, words 1..8
    m_axis_tready = 1'b1;
    b = obs_d.size(); r = rd_c.size();
    for (int i = 1; i <= 8; i++) push(64'(i));
    enable = 1'b1;
    wait_beats(b + 8, 40, "t1_beats");
    for (int i = 0; i < 8; i++) begin
      chk("t1_data", obs_d[b+i], 64'(i + 1));
      chk("t1_last", obs_l[b+i], (i % 4) == 3);
      chk("t1_b2b", obs_c[b+i] - obs_c[b], i);
    end
    chk("t1_latency", obs_c[b] - rd_c[r], 2);
    repeat (2) @(negedge clk_0);
    chk("t1_fcount", frame_count, 2);
    enable = 1'b0;
    repeat (2) @(negedge clk_0);
    chk("t1_busy_off", busy, 0);

    // tready toggling every cycle
    b = obs_d.size();
    for (int i = 0; i < 4; i++) push(64'h20 + 64'(i));
    enable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      m_axis_tready = (i % 2) == 1;
      @(negedge clk_0);
    end
    m_axis_tready = 1'b1;
    wait_beats(b + 4, 40, "t2_beats");
    for (int i = 0; i < 4; i++) begin
      chk("t2_data", obs_d[b+i], 64'h20 + 64'(i));
      chk("t2_last", obs_l[b+i], i == 3);
    end
    chk("t2_hold_stalled", stall_err, 0);
    chk("t2_credit", ovf_err, 0);
    enable = 1'b0;
    repeat (3) @(negedge clk_0);
    chk("t2_fcount", frame_count, 3);
    chk("t2_busy_off", busy, 0);

    // enable drops during beat 2 of a frame, 10 words available
    b = obs_d.size();
    for (int i = 0; i < 10; i++) push(64'h30 + 64'(i));
    enable = 1'b1;
    k = 0;
    while (obs_d.size() < b + 1 && k < 40) begin
      @(negedge clk_0);
      k++;
    end
    enable = 1'b0;
    repeat (12) @(negedge clk_0);
    chk("t3_beats", obs_d.size(), b + 4);
    for (int i = 0; i < 4; i++) begin
      chk("t3_data", obs_d[b+i], 64'h30 + 64'(i));
      chk("t3_last", obs_l[b+i], i == 3);
    end
    chk("t3_left", wr_ptr - rd_ptr, 6);
    chk("t3_busy_off", busy, 0);
    chk("t3_fcount", frame_count, 4);
    do_flush();

    // FIFO runs dry after beat 2 for 5 cycles
    b = obs_d.size();
    push(64'h40); push(64'h41);
    enable = 1'b1;
    wait_beats(b + 2, 30, "t4_first2");
    for (int i = 0; i < 5; i++) begin
      chk("t4_gap_tvalid", m_axis_tvalid, 0);
      @(negedge clk_0);
    end
    chk("t4_gap_busy", busy, 1);
    push(64'h42); push(64'h43);
    wait_beats(b + 4, 30, "t4_beats");
    for (int i = 0; i < 4; i++) begin
      chk("t4_data", obs_d[b+i], 64'h40 + 64'(i));
      chk("t4_last", obs_l[b+i], i == 3);
    end
    repeat (2) @(negedge clk_0);
    chk("t4_fcount", frame_count, 5);
    enable = 1'b0;
    repeat (3) @(negedge clk_0);

    // reset pulsed mid-frame
    b = obs_d.size();
    for (int i = 0; i < 8; i++) push(64'h50 + 64'(i));
    enable = 1'b1;
    wait_beats(b + 2, 30, "t5_pre");
    m_axis_tready = 1'b0;
    @(negedge clk_0);
    resetn_0 = 1'b0;
    #1;
    chk("t5_tvalid", m_axis_tvalid, 0);
    chk("t5_tlast", m_axis_tlast, 0);
    chk("t5_tdata", m_axis_tdata, 0);
    chk("t5_busy", busy, 0);
    chk("t5_rd_en", fifo_rd_en, 0);
    chk("t5_fcount", frame_count, 0);
    do_flush();
    b = obs_d.size();
    for (int i = 0; i < 4; i++) push(64'h60 + 64'(i));
    @(negedge clk_0);
    resetn_0 = 1'b1;
    m_axis_tready = 1'b1;
    wait_beats(b + 4, 30, "t5_beats");
    for (int i = 0; i < 4; i++) begin
      chk("t5_data", obs_d[b+i], 64'h60 + 64'(i));
      chk("t5_last", obs_l[b+i], i == 3);
    end
    repeat (3) @(negedge clk_0);
    chk("t5_fcount_after", frame_count, 1);
    enable = 1'b0;
    repeat (3) @(negedge clk_0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
